// File: rtl/goertzel_pkg.sv
// Shared FSM states, error bit positions and width helpers for the Goertzel bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package goertzel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINAL  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int ERR_LEN = 0;
  localparam int ERR_UP  = 1;

  // Coefficients are signed Q3.(COEF_W-3): 2cos() spans [-2, 2] with headroom.
  function automatic int q_frac(input int coef_w);
    return coef_w - 3;
  endfunction

  function automatic int acc_w(input int in_w, input int pts_w);
    return in_w + pts_w + 3;
  endfunction

endpackage

// File: rtl/goertzel_cell.sv
// One Goertzel bin: coefficient register, s1/s2 recursion and power pipeline.
// Latency: power valid 2 cycles after fin1_i (fin1_i then fin2_i on consecutive cycles).
// Backpressure: none; the parent only feeds samples it has accepted and holds power_o while unloading.
module goertzel_cell
  import goertzel_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int PTS_W     = 12,
  parameter int COEF_W    = 18,
  parameter int OUT_W     = 32,
  parameter int PWR_SHIFT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   smp_vld_i,
  input  logic                   smp_sop_i,
  input  logic signed [IN_W-1:0] smp_i,
  input  logic [COEF_W-1:0]      coef_i,
  input  logic                   fin1_i,
  input  logic                   fin2_i,
  output logic [OUT_W-1:0]       power_o
);

  localparam int AW = acc_w(IN_W, PTS_W);
  localparam int QF = q_frac(COEF_W);
  localparam int PW = 2 * AW;

  logic signed [COEF_W-1:0]    coef_q;
  logic signed [AW-1:0]        s1_q, s2_q;
  logic signed [AW+COEF_W-1:0] cs1;
  logic signed [AW-1:0]        fb, x_ext, s0;
  logic signed [PW-1:0]        s1_w, s2_w, fb_w, p_d, p_q;
  logic [PW-1:0]               p_pos, p_shift;
  logic [OUT_W-1:0]            pwr_d, pwr_q;

  assign cs1   = (AW+COEF_W)'(coef_q) * (AW+COEF_W)'(s1_q);
  assign fb    = AW'(cs1 >>> QF);
  assign x_ext = {{(AW-IN_W){smp_i[IN_W-1]}}, smp_i};
  assign s0    = x_ext + fb - s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else if (smp_vld_i) begin
      if (smp_sop_i) begin
        // The first sample sees zero history, so s0 is just the sample.
        coef_q <= coef_i;
        s1_q   <= x_ext;
        s2_q   <= '0;
      end else begin
        s1_q <= s0;
        s2_q <= s1_q;
      end
    end
  end

  assign s1_w = PW'(s1_q);
  assign s2_w = PW'(s2_q);
  assign fb_w = PW'(fb);
  assign p_d  = s1_w * s1_w + s2_w * s2_w - fb_w * s2_w;

  // Negative power is rounding noise; clamp before the unsigned shift.
  assign p_pos   = p_q[PW-1] ? '0 : p_q;
  assign p_shift = p_pos >> PWR_SHIFT;
  assign pwr_d   = (|p_shift[PW-1:OUT_W]) ? '1 : p_shift[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q   <= '0;
      pwr_q <= '0;
    end else begin
      if (fin1_i) p_q   <= p_d;
      if (fin2_i) pwr_q <= pwr_d;
    end
  end

  assign power_o = pwr_q;

endmodule

// File: rtl/goertzel_bank.sv
// Streaming Goertzel bank: per-frame power of N_BINS bins as one Avalon-ST packet.
// Latency: first source_valid 3 cycles after the eop beat is accepted.
// Backpressure: sink_ready low while finishing/unloading; output held while !source_ready. GOERTZEL_LEN_CHECK_EN adds length check.
module goertzel_bank
  import goertzel_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int PTS_W     = 12,
  parameter int N_BINS    = 4,
  parameter int COEF_W    = 18,
  parameter int OUT_W     = 32,
  parameter int PWR_SHIFT = 16,
  localparam int BIN_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic [1:0]               sink_error,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  input  logic signed [IN_W-1:0]   sink_real,
  input  logic [PTS_W-1:0]         fftpts_in,
  input  logic [N_BINS*COEF_W-1:0] coef_in,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic [1:0]               source_error,
  output logic                     source_sop,
  output logic                     source_eop,
  output logic [OUT_W-1:0]         source_power,
  output logic [BIN_W-1:0]         source_bin,
  output logic [PTS_W-1:0]         fftpts_out
);

  state_t           state_q;
  logic             fin_cnt_q;
  logic [BIN_W-1:0] bin_q;
  logic [PTS_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             sink_ready_q, source_valid_q;
  logic             beat, smp_vld, frame_end, len_bad, fin1, fin2;
  logic [OUT_W-1:0] pwr [N_BINS];

  assign beat    = sink_valid & sink_ready_q;
  assign smp_vld = beat & (sink_sop | (state_q == ACCUM));
  assign cnt_d   = sink_sop ? PTS_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + PTS_W'(1));
  assign fin1    = (state_q == FINAL) & ~fin_cnt_q;
  assign fin2    = (state_q == FINAL) & fin_cnt_q;

`ifdef GOERTZEL_LEN_CHECK_EN
  logic [PTS_W-1:0] len_q, len_d;
  logic             hit_len;

  assign len_d     = sink_sop ? fftpts_in : len_q;
  assign hit_len   = (cnt_d == len_d);
  assign frame_end = sink_eop | hit_len;
  assign len_bad   = sink_eop & ~hit_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        len_q <= '0;
    else if (smp_vld) len_q <= len_d;
  end
`else
  logic unused_pts;
  assign unused_pts = ^fftpts_in;
  assign frame_end  = sink_eop;
  assign len_bad    = 1'b0;
`endif

  always_comb begin
    err_d = sink_sop ? 2'b00 : err_q;
    if (|sink_error) err_d[ERR_UP] = 1'b1;
    err_d[ERR_LEN] = len_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      fin_cnt_q      <= 1'b0;
      bin_q          <= '0;
      cnt_q          <= '0;
      err_q          <= '0;
      sink_ready_q   <= 1'b0;
      source_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          sink_ready_q <= 1'b1;
          if (smp_vld) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (frame_end) begin
              state_q      <= FINAL;
              fin_cnt_q    <= 1'b0;
              sink_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        FINAL: begin
          if (fin_cnt_q) begin
            state_q        <= OUTPUT;
            bin_q          <= '0;
            source_valid_q <= 1'b1;
          end else begin
            fin_cnt_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (source_ready) begin
            if (bin_q == BIN_W'(N_BINS - 1)) begin
              state_q        <= IDLE;
              bin_q          <= '0;
              source_valid_q <= 1'b0;
              sink_ready_q   <= 1'b1;
            end else begin
              bin_q <= bin_q + BIN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_BINS; k++) begin : g_bin
    goertzel_cell #(
      .IN_W      (IN_W),
      .PTS_W     (PTS_W),
      .COEF_W    (COEF_W),
      .OUT_W     (OUT_W),
      .PWR_SHIFT (PWR_SHIFT)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .smp_vld_i (smp_vld),
      .smp_sop_i (sink_sop),
      .smp_i     (sink_real),
      .coef_i    (coef_in[k*COEF_W +: COEF_W]),
      .fin1_i    (fin1),
      .fin2_i    (fin2),
      .power_o   (pwr[k])
    );
  end

  assign sink_ready   = sink_ready_q;
  assign source_valid = source_valid_q;
  assign source_sop   = source_valid_q & (bin_q == '0);
  assign source_eop   = source_valid_q & (bin_q == BIN_W'(N_BINS - 1));
  assign source_power = source_valid_q ? pwr[bin_q] : '0;
  assign source_bin   = bin_q;
  assign source_error = err_q;
  assign fftpts_out   = cnt_q;

endmodule

// File: tb/tb_goertzel_bank.sv
// Directed bench for goertzel_bank: DC, sine, backpressure, restart, length, error and reset scenarios.
module tb_goertzel_bank;
  localparam int IN_W   = 16;
  localparam int PTS_W  = 12;
  localparam int N_BINS = 4;
  localparam int COEF_W = 18;
  localparam int OUT_W  = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]               sink_error;
  logic signed [IN_W-1:0]   sink_real;
  logic [PTS_W-1:0]         fftpts_in;
  logic [N_BINS*COEF_W-1:0] coef_in;
  logic                     source_valid, source_ready, source_sop, source_eop;
  logic [1:0]               source_error;
  logic [OUT_W-1:0]         source_power;
  logic [1:0]               source_bin;
  logic [PTS_W-1:0]         fftpts_out;

  int checks = 0;
  int errors = 0;
  int pkt_cnt = 0;

  logic [OUT_W-1:0] got_pwr [N_BINS];
  logic [1:0]       got_bin [N_BINS];
  logic [1:0]       got_err;
  logic [PTS_W-1:0] got_pts;
  int               got_n, got_sops, got_eops;
  bit               got_to;

  goertzel_bank dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_error   (sink_error),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .fftpts_in    (fftpts_in),
    .coef_in      (coef_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_error (source_error),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_power (source_power),
    .source_bin   (source_bin),
    .fftpts_out   (fftpts_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (source_valid && source_ready && source_sop) pkt_cnt++;

  task automatic drive_beat(input logic signed [15:0] x, input logic sop, input logic eop,
                            input logic [1:0] er);
    int waitc = 0;
    sink_valid = 1'b1; sink_real = x; sink_sop = sop; sink_eop = eop; sink_error = er;
    while (!sink_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
    if (!sink_ready) begin
      checks++; errors++;
      $display("FAIL sink_ready_timeout got=%0b want=1", sink_ready);
    end
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
  endtask

  task automatic send_frame(input int x, input int n, input bit eop_last, input int err_at,
                            input logic [1:0] errv);
    for (int i = 0; i < n; i++)
      drive_beat(16'(x), i == 0, eop_last && (i == n - 1), (i == err_at) ? errv : 2'b00);
  endtask

  task automatic collect();
    int waitc = 0;
    got_to = 1'b0; got_n = 0; got_sops = 0; got_eops = 0;
    for (int b = 0; b < N_BINS; b++) begin got_pwr[b] = '1; got_bin[b] = '1; end
    source_ready = 1'b1;
    while (!source_valid && waitc < 300) begin @(posedge clk); #1; waitc++; end
    if (!source_valid) begin got_to = 1'b1; return; end
    got_err = source_error; got_pts = fftpts_out;
    while (source_valid && got_n < 8) begin
      if (got_n < N_BINS) begin got_pwr[got_n] = source_power; got_bin[got_n] = source_bin; end
      got_sops += int'(source_sop); got_eops += int'(source_eop); got_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL rst_sink_ready got=%b want=0", sink_ready); end
    checks++; if ({source_valid, source_sop, source_eop} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b want=000", {source_valid, source_sop, source_eop}); end
    checks++; if (source_power !== '0 || source_error !== 2'b00 || fftpts_out !== '0 || source_bin !== 2'd0) begin errors++; $display("FAIL rst_data got=%0d/%b/%0d/%0d want=0", source_power, source_error, fftpts_out, source_bin); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", sink_ready); end
  endtask

  task automatic test_dc();
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL dc_lat_c1 got=%b want=0", source_valid); end
    @(posedge clk); #1;
    checks++; if (source_valid !== 1'b0 || sink_ready !== 1'b0) begin errors++; $display("FAIL dc_lat_c2 got=%b/%b want=0/0", source_valid, sink_ready); end
    @(posedge clk); #1;
    checks++; if (source_valid !== 1'b1) begin errors++; $display("FAIL dc_lat_c3 got=%b want=1", source_valid); end
    collect();
    checks++; if (got_to || got_n != 4 || got_sops != 1 || got_eops != 1) begin errors++; $display("FAIL dc_pkt got=%0d/%0d/%0d want=4/1/1", got_n, got_sops, got_eops); end
    checks++; if (got_pwr[0] !== 32'd62500) begin errors++; $display("FAIL dc_bin0 got=%0d want=62500", got_pwr[0]); end
    checks++; if (got_pwr[1] >= 64 || got_pwr[2] >= 64) begin errors++; $display("FAIL dc_bin12 got=%0d/%0d want=<64", got_pwr[1], got_pwr[2]); end
    checks++; if (got_pwr[3] !== 32'd0) begin errors++; $display("FAIL dc_bin3 got=%0d want=0", got_pwr[3]); end
    checks++; if (got_err !== 2'b00 || got_pts !== 12'd64) begin errors++; $display("FAIL dc_meta got=%b/%0d want=00/64", got_err, got_pts); end
    checks++; if (got_bin[0] !== 2'd0 || got_bin[1] !== 2'd1 || got_bin[2] !== 2'd2 || got_bin[3] !== 2'd3) begin errors++; $display("FAIL dc_bins got=%0d%0d%0d%0d want=0123", got_bin[0], got_bin[1], got_bin[2], got_bin[3]); end
  endtask

  task automatic test_single();
    fftpts_in = 12'd1;
    drive_beat(16'sd5000, 1'b0, 1'b0, 2'b00);
    checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got=%b want=1", sink_ready); end
    drive_beat(16'sd1000, 1'b1, 1'b1, 2'b00);
    collect();
    checks++; if (got_to || got_n != 4) begin errors++; $display("FAIL single_pkt got=%0d want=4", got_n); end
    for (int b = 0; b < N_BINS; b++) begin
      checks++; if (got_pwr[b] !== 32'd15) begin errors++; $display("FAIL single_bin%0d got=%0d want=15", b, got_pwr[b]); end
    end
    checks++; if (got_err !== 2'b00 || got_pts !== 12'd1) begin errors++; $display("FAIL single_meta got=%b/%0d want=00/1", got_err, got_pts); end
    fftpts_in = 12'd64;
  endtask

  task automatic test_sine();
    logic signed [15:0] tab [8] = '{16'sd0, 16'sd5793, 16'sd8192, 16'sd5793,
                                    16'sd0, -16'sd5793, -16'sd8192, -16'sd5793};
    for (int i = 0; i < 64; i++) drive_beat(tab[i % 8], i == 0, i == 63, 2'b00);
    collect();
    checks++; if (got_to || got_n != 4) begin errors++; $display("FAIL sine_pkt got=%0d want=4", got_n); end
    checks++; if (got_pwr[1] < 32'd1038090 || got_pwr[1] > 32'd1059062) begin errors++; $display("FAIL sine_bin1 got=%0d want=1048576+/-1%%", got_pwr[1]); end
    for (int b = 0; b < N_BINS; b++) begin
      if (b != 1) begin
        checks++; if (got_pwr[b] >= 32'd10486) begin errors++; $display("FAIL sine_leak%0d got=%0d want=<10486", b, got_pwr[b]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int beats = 0, sops = 0, eops = 0, cyc = 0, vcyc = 0;
    logic pv = 1'b0, pr = 1'b0, psop = 1'b0, peop = 1'b0, ok;
    logic [OUT_W-1:0] ppwr = '0;
    logic [1:0] pbin = '0, perr = '0;
    logic [PTS_W-1:0] ppts = '0;
    source_ready = 1'b0;
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    while (beats < 4 && cyc < 300) begin
      if (pv && !pr) begin
        checks++;
        if (source_valid !== 1'b1 || source_power !== ppwr || source_bin !== pbin || source_sop !== psop ||
            source_eop !== peop || source_error !== perr || fftpts_out !== ppts) begin
          errors++; $display("FAIL bp_hold got=%b/%0d/%0d want=1/%0d/%0d", source_valid, source_power, source_bin, ppwr, pbin);
        end
      end
      source_ready = (vcyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (source_valid) vcyc++;
      if (source_valid && source_ready) begin
        checks++; if (source_bin !== 2'(beats)) begin errors++; $display("FAIL bp_bin got=%0d want=%0d", source_bin, beats); end
        case (beats)
          0:       ok = (source_power === 32'd62500);
          3:       ok = (source_power === 32'd0);
          default: ok = (source_power < 32'd64);
        endcase
        checks++; if (!ok) begin errors++; $display("FAIL bp_pwr%0d got=%0d", beats, source_power); end
        beats++; sops += int'(source_sop); eops += int'(source_eop);
      end
      pv = source_valid; pr = source_ready; ppwr = source_power; pbin = source_bin;
      psop = source_sop; peop = source_eop; perr = source_error; ppts = fftpts_out;
      @(posedge clk); #1; cyc++;
    end
    source_ready = 1'b1;
    checks++; if (beats != 4 || sops != 1 || eops != 1) begin errors++; $display("FAIL bp_count got=%0d/%0d/%0d want=4/1/1", beats, sops, eops); end
    repeat (3) @(posedge clk); #1;
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL bp_after got=%b want=0", source_valid); end
  endtask

  task automatic test_restart();
    int p0 = pkt_cnt;
    send_frame(3000, 20, 1'b0, -1, 2'b00);
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    collect();
    repeat (10) @(posedge clk); #1;
    checks++; if (pkt_cnt - p0 != 1) begin errors++; $display("FAIL restart_pkts got=%0d want=1", pkt_cnt - p0); end
    checks++; if (got_pwr[0] !== 32'd62500 || got_pts !== 12'd64 || got_err !== 2'b00) begin errors++; $display("FAIL restart_data got=%0d/%0d/%b want=62500/64/00", got_pwr[0], got_pts, got_err); end
  endtask

  task automatic test_len();
    send_frame(1000, 60, 1'b1, -1, 2'b00);
    collect();
`ifdef GOERTZEL_LEN_CHECK_EN
    checks++; if (got_to || got_err !== 2'b01 || got_pts !== 12'd60) begin errors++; $display("FAIL len_short got=%b/%0d want=01/60", got_err, got_pts); end
`else
    checks++; if (got_to || got_err !== 2'b00 || got_pts !== 12'd60) begin errors++; $display("FAIL len_short got=%b/%0d want=00/60", got_err, got_pts); end
`endif
    checks++; if (got_pwr[0] !== 32'd54931) begin errors++; $display("FAIL len_short_pwr got=%0d want=54931", got_pwr[0]); end
    send_frame(1000, 64, 1'b0, -1, 2'b00);
`ifdef GOERTZEL_LEN_CHECK_EN
    collect();
    checks++; if (got_to || got_err !== 2'b00 || got_pts !== 12'd64 || got_pwr[0] !== 32'd62500) begin errors++; $display("FAIL len_forced got=%b/%0d/%0d want=00/64/62500", got_err, got_pts, got_pwr[0]); end
    fftpts_in = 12'd0;
    drive_beat(16'sd1000, 1'b1, 1'b1, 2'b00);
    collect();
    checks++; if (got_to || got_err !== 2'b01 || got_pts !== 12'd1) begin errors++; $display("FAIL len_zero got=%b/%0d want=01/1", got_err, got_pts); end
    fftpts_in = 12'd64;
`else
    repeat (20) @(posedge clk); #1;
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL len_noforce got=%b want=0", source_valid); end
    drive_beat(16'sd1000, 1'b0, 1'b1, 2'b00);
    collect();
    checks++; if (got_to || got_err !== 2'b00 || got_pts !== 12'd65 || got_pwr[0] !== 32'd64468) begin errors++; $display("FAIL len_65 got=%b/%0d/%0d want=00/65/64468", got_err, got_pts, got_pwr[0]); end
`endif
  endtask

  task automatic test_error();
    send_frame(1000, 64, 1'b1, 5, 2'b10);
    collect();
    checks++; if (got_to || got_err !== 2'b10 || got_pwr[0] !== 32'd62500) begin errors++; $display("FAIL err_sticky got=%b/%0d want=10/62500", got_err, got_pwr[0]); end
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    collect();
    checks++; if (got_to || got_err !== 2'b00) begin errors++; $display("FAIL err_clear got=%b want=00", got_err); end
  endtask

  task automatic test_reset_output();
    int waitc = 0;
    bit seen = 1'b0;
    source_ready = 1'b0;
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    while (!source_valid && waitc < 20) begin @(posedge clk); #1; waitc++; end
    checks++; if (source_valid !== 1'b1) begin errors++; $display("FAIL rsto_valid got=%b want=1", source_valid); end
    @(posedge clk); #1;
    reset = 1'b1; #1;
    checks++; if ({source_valid, source_sop, sink_ready} !== 3'b000 || source_power !== '0) begin errors++; $display("FAIL rsto_outputs got=%b/%0d want=000/0", {source_valid, source_sop, sink_ready}, source_power); end
    checks++; if (source_error !== 2'b00 || fftpts_out !== '0) begin errors++; $display("FAIL rsto_meta got=%b/%0d want=00/0", source_error, fftpts_out); end
    @(posedge clk); #1;
    reset = 1'b0; source_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (source_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rsto_stale got=1 want=0"); end
    send_frame(1000, 64, 1'b1, -1, 2'b00);
    collect();
    checks++; if (got_to || got_n != 4 || got_pwr[0] !== 32'd62500 || got_pts !== 12'd64 || got_err !== 2'b00) begin errors++; $display("FAIL rsto_next got=%0d/%0d/%0d/%b want=4/62500/64/00", got_n, got_pwr[0], got_pts, got_err); end
  endtask

  initial begin
    reset = 1'b1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00; sink_real = '0;
    source_ready = 1'b1;
    fftpts_in = 12'd64;
    coef_in = {18'd0, 18'd60548, 18'd46341, 18'd65536};
    test_reset();
    test_dc();
    test_single();
    test_sine();
    test_back_to_back();
    test_restart();
    test_len();
    test_error();
    test_reset_output();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
